capture_input_conditioner: RTL and testbench
============================================

# capture_input_conditioner

Conditions the raw, asynchronous per-channel start, capture and capture-reset inputs into clean single-cycle rising-edge pulses for the capture FSM stage that follows it. Each of the 3×NB_CAPTURES lanes does three things in order: it synchronizes the input into clk_i, applies a stable-count glitch filter, and detects rising edges on the filtered level. Its pulse outputs connect bit-for-bit to the capture FSM's start/capture/rst_capture rising inputs.

## Interface
- NB_CAPTURES, 10, number of capture channels
- SYNC_STAGES, 2, synchronizer depth; legal range ≥2
- FILTER_LEN, 4, consecutive stable synchronized cycles required to accept a level change; legal range ≥1
- clk_i  in  1  system clock
- rst_an_i  in  1  reset, asynchronous, active-low; clock clk_i
- rst_i  in  1  synchronous reset, active-high
- start_in_i  in  NB_CAPTURES  raw asynchronous start inputs
- capture_in_i  in  NB_CAPTURES  raw asynchronous capture inputs
- rst_capture_in_i  in  NB_CAPTURES  raw asynchronous capture-reset inputs
- start_in_rising_o  out  NB_CAPTURES  one-cycle pulse on each filtered rising edge of start
- capture_in_rising_o  out  NB_CAPTURES  one-cycle pulse on each filtered rising edge of capture
- rst_capture_in_rising_o  out  NB_CAPTURES  one-cycle pulse on each filtered rising edge of capture-reset
- level_o  out  3*NB_CAPTURES  filtered levels, packed as {rst_capture, capture, start}; channel i of group g is at bit g*NB_CAPTURES+i

## Operation
- There are 3×NB_CAPTURES lanes. All lanes are identical and independent.
- Synchronizer: a SYNC_STAGES-deep flop chain. Call its last stage s.
- Filter state per lane: level (1 bit) and cnt (width $clog2(FILTER_LEN), minimum 1).
  - On each clock where s == level: cnt <= 0. Any stable cycle restarts the count, so glitches are rejected.
  - On each clock where s != level and cnt < FILTER_LEN-1: cnt <= cnt+1.
  - On each clock where s != level and cnt == FILTER_LEN-1: level <= s and cnt <= 0.
  - FILTER_LEN=1 means level follows s with one register of delay.
- Edge detect: the rising output is registered and asserted for exactly the one cycle after level transitions 0→1. A falling transition produces no pulse.
- rst_an_i low (asynchronous): all sync flops, level, cnt and rising outputs are cleared to 0.
- rst_i high (synchronous): level, cnt and rising outputs are cleared to 0. Sync chains keep sampling.
- Reset values: all outputs are 0.
- Consequence of level resetting to 0: if an input is held high through reset, the lane emits exactly one rising pulse FILTER_LEN cycles after the synchronized value is seen post-reset. The downstream stage tolerates this.
- No arbitration between groups. Start, capture and rst_capture pulses for the same channel may coincide in one cycle; priority is the downstream stage's responsibility.

## Timing
- Latency, from the first clk_i edge that samples a clean input rising edge to the rising pulse being high: SYNC_STAGES+FILTER_LEN edges.
  - The pulse is high after edge SYNC_STAGES+FILTER_LEN and low after the next edge.
  - With defaults this is 6 edges.
- Minimum accepted pulse width: FILTER_LEN consecutive samples of s at the new value. Shorter excursions leave level unchanged and produce no output.
- Minimum spacing between two accepted rising edges: 2×FILTER_LEN cycles (high filter time plus low filter time).
- rst_i asserted mid-filter: cnt is cleared, and the accepting edge restarts FILTER_LEN cycles after rst_i deasserts. A pulse scheduled in the same cycle as rst_i is suppressed.
- Throughput: one pulse per lane per accepted edge. No backpressure.

## Structure
- Shared package capture_pkg:
  - group indices GRP_START=0, GRP_CAPTURE=1, GRP_RST_CAPTURE=2, and NB_GROUPS=3
  - a function computing cnt width from FILTER_LEN (clog2, minimum 1)
- Sub-module input_edge_lane (parameters SYNC_STAGES, FILTER_LEN; ports clk_i, rst_an_i, rst_i, in_i, level_o, rising_o) contains the synchronizer, filter and edge detect for a single lane.
- The top instantiates 3×NB_CAPTURES lanes with a generate loop and packs the outputs.

## Test plan
- Async reset and hold: assert rst_an_i low with all inputs toggling → all outputs 0 throughout. Release with inputs at 0 → no pulses for 50 cycles.
- Clean edge (defaults): start_in_i[3] goes 0→1 just before edge 1 and is held → start_in_rising_o[3] is high only after edge 6, level_o[3] is 1 from edge 6, and no other bit changes.
- Glitch rejection: capture_in_i[0] is high for exactly 3 cycles (FILTER_LEN-1 synchronized samples), then low → no pulse, level_o[10] stays 0. Repeat with a 4-cycle high → exactly one pulse.
- Chatter: rst_capture_in_i[9] toggles pattern 1,1,0,1,1,1,1 → the count restarts after the 0, and a single pulse appears 4 stable samples after the last restart.
- Sync reset mid-filter: raise start_in_i[5], then assert rst_i for 1 cycle at edge 4 → no pulse at edge 6, and a pulse at 4 cycles after rst_i deasserts.
- All lanes simultaneously: raise all 30 inputs in the same cycle → all 30 rising bits pulse together at edge 6 and level_o = 30'h3FFFFFFF. Drop all inputs → no pulses, and level_o returns to 0 after 6 edges.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared definitions for the capture input conditioning path.
//   - Group indices used to pack the start / capture / capture-reset lanes.
//   - cnt_width(): width of a glitch-filter counter for a given filter length.
package capture_pkg;

  localparam int GRP_START       = 0;
  localparam int GRP_CAPTURE     = 1;
  localparam int GRP_RST_CAPTURE = 2;
  localparam int NB_GROUPS       = 3;

  // Counter must hold 0..filter_len-1; never narrower than one bit.
  function automatic int cnt_width(input int filter_len);
    return (filter_len <= 1) ? 1 : $clog2(filter_len);
  endfunction

endpackage

// File: rtl/input_edge_lane.sv
// input_edge_lane
//   One conditioning lane: synchronizer, stable-count glitch filter and
//   registered rising-edge detector.
//   Ports:
//     clk_i     system clock
//     rst_an_i  asynchronous active-low reset (clears everything)
//     rst_i     synchronous active-high reset (clears filter and edge output,
//               synchronizer keeps sampling)
//     in_i      raw asynchronous input
//     level_o   filtered level
//     rising_o  one-cycle pulse, high in the cycle after level goes 0->1
module input_edge_lane
  import capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk_i,
  input  logic rst_an_i,
  input  logic rst_i,
  input  logic in_i,
  output logic level_o,
  output logic rising_o
);

  localparam int              CNT_W   = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rising_q, rising_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // The rising pulse is produced on the same edge that accepts the new level,
  // so level_o and rising_o rise together.
  always_comb begin
    level_d  = level_q;
    cnt_d    = cnt_q;
    rising_d = 1'b0;
    if (rst_i) begin
      level_d = 1'b0;
      cnt_d   = '0;
    end else if (sync_s == level_q) begin
      // Any sample matching the current level restarts the stability count.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d  = sync_s;
      cnt_d    = '0;
      rising_d = sync_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      rising_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      rising_q <= rising_d;
    end
  end

  assign level_o  = level_q;
  assign rising_o = rising_q;

endmodule

// File: rtl/capture_input_conditioner.sv
// capture_input_conditioner
//   Turns raw asynchronous start / capture / capture-reset inputs into clean
//   single-cycle rising-edge pulses for the capture FSM.
//   Ports:
//     clk_i, rst_an_i (async, active-low), rst_i (sync, active-high)
//     start_in_i, capture_in_i, rst_capture_in_i      raw inputs, NB_CAPTURES each
//     start_in_rising_o, capture_in_rising_o,
//     rst_capture_in_rising_o                         rising pulses, NB_CAPTURES each
//     level_o   filtered levels packed {rst_capture, capture, start};
//               channel i of group g at bit g*NB_CAPTURES+i
module capture_input_conditioner
  import capture_pkg::*;
#(
  parameter int NB_CAPTURES = 10,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_an_i,
  input  logic                             rst_i,
  input  logic [NB_CAPTURES-1:0]           start_in_i,
  input  logic [NB_CAPTURES-1:0]           capture_in_i,
  input  logic [NB_CAPTURES-1:0]           rst_capture_in_i,
  output logic [NB_CAPTURES-1:0]           start_in_rising_o,
  output logic [NB_CAPTURES-1:0]           capture_in_rising_o,
  output logic [NB_CAPTURES-1:0]           rst_capture_in_rising_o,
  output logic [NB_GROUPS*NB_CAPTURES-1:0] level_o
);

  localparam int NB_LANES = NB_GROUPS * NB_CAPTURES;

  logic [NB_LANES-1:0] in_all;
  logic [NB_LANES-1:0] level_all;
  logic [NB_LANES-1:0] rising_all;

  assign in_all[GRP_START*NB_CAPTURES       +: NB_CAPTURES] = start_in_i;
  assign in_all[GRP_CAPTURE*NB_CAPTURES     +: NB_CAPTURES] = capture_in_i;
  assign in_all[GRP_RST_CAPTURE*NB_CAPTURES +: NB_CAPTURES] = rst_capture_in_i;

  for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
    input_edge_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_an_i (rst_an_i),
      .rst_i    (rst_i),
      .in_i     (in_all[l]),
      .level_o  (level_all[l]),
      .rising_o (rising_all[l])
    );
  end

  assign start_in_rising_o       = rising_all[GRP_START*NB_CAPTURES       +: NB_CAPTURES];
  assign capture_in_rising_o     = rising_all[GRP_CAPTURE*NB_CAPTURES     +: NB_CAPTURES];
  assign rst_capture_in_rising_o = rising_all[GRP_RST_CAPTURE*NB_CAPTURES +: NB_CAPTURES];
  assign level_o                 = level_all;

endmodule

// File: tb/tb_capture_input_conditioner.sv
module tb_capture_input_conditioner;

  localparam int NB   = 10;
  localparam int SYNC = 2;
  localparam int FLEN = 4;
  localparam int NL   = 3 * NB;
  localparam int HMAX = 8192;

  logic          clk_i = 1'b0;
  logic          rst_an_i;
  logic          rst_i;
  logic [NB-1:0] start_in_i, capture_in_i, rst_capture_in_i;
  logic [NB-1:0] start_in_rising_o, capture_in_rising_o, rst_capture_in_rising_o;
  logic [NL-1:0] level_o;
  logic [NL-1:0] dut_rise;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  capture_input_conditioner #(
    .NB_CAPTURES (NB),
    .SYNC_STAGES (SYNC),
    .FILTER_LEN  (FLEN)
  ) dut (
    .clk_i                   (clk_i),
    .rst_an_i                (rst_an_i),
    .rst_i                   (rst_i),
    .start_in_i              (start_in_i),
    .capture_in_i            (capture_in_i),
    .rst_capture_in_i        (rst_capture_in_i),
    .start_in_rising_o       (start_in_rising_o),
    .capture_in_rising_o     (capture_in_rising_o),
    .rst_capture_in_rising_o (rst_capture_in_rising_o),
    .level_o                 (level_o)
  );

  assign dut_rise = {rst_capture_in_rising_o, capture_in_rising_o, start_in_rising_o};

  // Reference model: a level flips when the last FLEN synchronized samples
  // (all taken since the last reset or flip) disagree with it. The synchronized
  // sample at edge k is the raw input seen SYNC edges earlier.
  bit [NL-1:0] raw_h [HMAX];
  bit [NL-1:0] s_h   [HMAX];
  int          k;
  int          win_start [NL];
  bit [NL-1:0] exp_level, exp_rise;

  function automatic void model_reset();
    k         = 0;
    exp_level = '0;
    exp_rise  = '0;
    for (int l = 0; l < NL; l++) win_start[l] = 0;
  endfunction

  function automatic void model_edge();
    bit ok;
    if (!rst_an_i) begin
      model_reset();
      return;
    end
    if (k >= HMAX) return;
    raw_h[k] = {rst_capture_in_i, capture_in_i, start_in_i};
    s_h[k]   = (k >= SYNC) ? raw_h[k-SYNC] : '0;
    for (int l = 0; l < NL; l++) begin
      exp_rise[l] = 1'b0;
      if (rst_i) begin
        exp_level[l] = 1'b0;
        win_start[l] = k + 1;
      end else if (k - FLEN + 1 >= win_start[l]) begin
        ok = 1'b1;
        for (int j = k - FLEN + 1; j <= k; j++)
          if (s_h[j][l] == exp_level[l]) ok = 1'b0;
        if (ok) begin
          exp_level[l] = s_h[k][l];
          exp_rise[l]  = s_h[k][l];
          win_start[l] = k + 1;
        end
      end
    end
    k++;
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic set_inputs(input bit [NL-1:0] v);
    {rst_capture_in_i, capture_in_i, start_in_i} = v;
  endtask

  task automatic settle(input string name, input int n);
    set_inputs('0);
    for (int c = 0; c < n; c++) begin
      cycle();
      n_chk++;
      if (level_o !== exp_level || dut_rise !== exp_rise) begin
        n_fail++;
        $display("FAIL %s c=%0d got lvl=%h rise=%h exp lvl=%h rise=%h",
                 name, c, level_o, dut_rise, exp_level, exp_rise);
      end
    end
  endtask

  task automatic test_reset();
    rst_an_i = 1'b0;
    rst_i    = 1'b0;
    set_inputs('0);
    model_reset();
    for (int c = 0; c < 12; c++) begin
      set_inputs({$urandom, $urandom} & {NL{1'b1}});
      cycle();
      n_chk++;
      if (level_o !== '0 || dut_rise !== '0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got lvl=%h rise=%h exp 0", c, level_o, dut_rise);
      end
    end
    set_inputs('0);
    rst_an_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      cycle();
      n_chk++;
      if (level_o !== '0 || dut_rise !== '0) begin
        n_fail++;
        $display("FAIL reset_release c=%0d got lvl=%h rise=%h exp 0", c, level_o, dut_rise);
      end
    end
  endtask

  task automatic test_clean_edge();
    bit [NL-1:0] el, er;
    set_inputs(NL'(1) << 3);
    for (int e = 1; e <= 8; e++) begin
      cycle();
      el = (e >= 6) ? NL'(1) << 3 : '0;
      er = (e == 6) ? NL'(1) << 3 : '0;
      n_chk++;
      if (level_o !== el || dut_rise !== er) begin
        n_fail++;
        $display("FAIL clean_edge e=%0d got lvl=%h rise=%h exp lvl=%h rise=%h",
                 e, level_o, dut_rise, el, er);
      end
    end
    settle("clean_edge_settle", 12);
  endtask

  task automatic test_glitch(input int width);
    bit [NL-1:0] el, er;
    for (int e = 1; e <= 14; e++) begin
      set_inputs((e <= width) ? NL'(1) << 10 : '0);
      cycle();
      el = (width >= FLEN && e >= 6 && e < 6 + FLEN) ? NL'(1) << 10 : '0;
      er = (width >= FLEN && e == 6) ? NL'(1) << 10 : '0;
      n_chk++;
      if (level_o !== el || dut_rise !== er) begin
        n_fail++;
        $display("FAIL glitch_w%0d e=%0d got lvl=%h rise=%h exp lvl=%h rise=%h",
                 width, e, level_o, dut_rise, el, er);
      end
    end
    settle("glitch_settle", 8);
  endtask

  task automatic test_chatter();
    bit          pat [7] = '{1, 1, 0, 1, 1, 1, 1};
    bit [NL-1:0] el, er;
    for (int e = 1; e <= 16; e++) begin
      set_inputs((e <= 7 && pat[e-1]) ? NL'(1) << 29 : '0);
      cycle();
      el = (e >= 9 && e < 13) ? NL'(1) << 29 : '0;
      er = (e == 9) ? NL'(1) << 29 : '0;
      n_chk++;
      if (level_o !== el || dut_rise !== er) begin
        n_fail++;
        $display("FAIL chatter e=%0d got lvl=%h rise=%h exp lvl=%h rise=%h",
                 e, level_o, dut_rise, el, er);
      end
    end
    settle("chatter_settle", 8);
  endtask

  task automatic test_sync_reset();
    bit [NL-1:0] el, er;
    set_inputs(NL'(1) << 5);
    for (int e = 1; e <= 12; e++) begin
      rst_i = (e == 4);
      cycle();
      el = (e >= 8) ? NL'(1) << 5 : '0;
      er = (e == 8) ? NL'(1) << 5 : '0;
      n_chk++;
      if (level_o !== el || dut_rise !== er) begin
        n_fail++;
        $display("FAIL sync_reset e=%0d got lvl=%h rise=%h exp lvl=%h rise=%h",
                 e, level_o, dut_rise, el, er);
      end
    end
    rst_i = 1'b0;
    settle("sync_reset_settle", 12);
  endtask

  task automatic test_all_lanes();
    bit [NL-1:0] el, er;
    for (int e = 1; e <= 16; e++) begin
      set_inputs((e <= 8) ? '1 : '0);
      cycle();
      el = (e >= 6 && e < 14) ? 30'h3FFFFFFF : '0;
      er = (e == 6) ? 30'h3FFFFFFF : '0;
      n_chk++;
      if (level_o !== el || dut_rise !== er) begin
        n_fail++;
        $display("FAIL all_lanes e=%0d got lvl=%h rise=%h exp lvl=%h rise=%h",
                 e, level_o, dut_rise, el, er);
      end
    end
    settle("all_lanes_settle", 8);
  endtask

  task automatic test_random();
    bit [NL-1:0] cur = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < NL; l++)
        if ($urandom_range(7) == 0) cur[l] = ~cur[l];
      set_inputs(cur);
      rst_i = ($urandom_range(63) == 0);
      cycle();
      n_chk++;
      if (level_o !== exp_level || dut_rise !== exp_rise) begin
        n_fail++;
        $display("FAIL random c=%0d got lvl=%h rise=%h exp lvl=%h rise=%h",
                 c, level_o, dut_rise, exp_level, exp_rise);
      end
    end
    rst_i = 1'b0;
    settle("random_settle", 12);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_edge();
    test_glitch(3);
    test_glitch(4);
    test_chatter();
    test_sync_reset();
    test_all_lanes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
